wave_gen: RTL and testbench

WAVE_GEN -- requirements
Module: wave_gen

---
 rtl/wave_gen_if.sv | 22 ++
 rtl/wave_gen.sv | 78 +++++++
 tb/tb_wave_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wave_gen_if.sv
// Control and sample bundle for wave_gen: gate requests, frequency/shape controls
// and the registered output sample.
interface wave_gen_if #(
    parameter int WAVE_DEPTH = 8
) ();
    logic                  GateOpen;
    logic                  GateClose;
    logic [WAVE_DEPTH-1:0] Incr;
    logic [1:0]            WaveType;
    logic [WAVE_DEPTH-1:0] PulseWidth;
    logic [WAVE_DEPTH-1:0] Waveform;

    modport master (
        output GateOpen, GateClose, Incr, WaveType, PulseWidth,
        input  Waveform
    );

    modport slave (
        input  GateOpen, GateClose, Incr, WaveType, PulseWidth,
        output Waveform
    );
endinterface

// File: rtl/wave_gen.sv
// Gated phase-accumulator waveform generator (saw, pulse, triangle, reverse saw).
// Optional amplitude envelope is compiled in with WAVE_GEN_ENVELOPE_EN.
module wave_gen #(
    parameter int WAVE_DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    wave_gen_if.slave   bus
);
    localparam int D = WAVE_DEPTH;

    logic         r_gate;
    logic [D-1:0] r_phase;
    logic [D-1:0] r_wave;
    logic [D-1:0] w_tri;
    logic [D-1:0] w_shape;
    logic [D-1:0] w_next_wave;
    logic         w_run;

    always_comb begin
        w_tri   = {r_phase[D-2:0], 1'b0};
        w_shape = '0;
        case (bus.WaveType)
            2'b00:   w_shape = r_phase;
            2'b01:   w_shape = (r_phase < bus.PulseWidth) ? '1 : '0;
            2'b10:   w_shape = r_phase[D-1] ? ~w_tri : w_tri;
            default: w_shape = ~r_phase;
        endcase
    end

`ifdef WAVE_GEN_ENVELOPE_EN
    logic [D-1:0]   r_env;
    logic [2*D-1:0] w_prod;

    // Full-scale envelope bypasses the multiply so the peak reaches all-ones.
    always_comb begin
        w_prod      = w_shape * r_env;
        w_next_wave = (&r_env) ? w_shape : w_prod[2*D-1:D];
        w_run       = r_gate | (r_env != '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_env <= '0;
        end else if (r_gate) begin
            if (!(&r_env)) r_env <= r_env + 1'b1;
        end else if (r_env != '0) begin
            r_env <= r_env - 1'b1;
        end
    end
`else
    always_comb begin
        w_next_wave = r_gate ? w_shape : '0;
        w_run       = r_gate;
    end
`endif

    // Open beats close; phase only advances on edges with no gate request.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_gate  <= 1'b0;
            r_phase <= '0;
            r_wave  <= '0;
        end else begin
            if (bus.GateOpen) begin
                r_gate  <= 1'b1;
                r_phase <= '0;
            end else if (bus.GateClose) begin
                r_gate  <= 1'b0;
            end else if (w_run) begin
                r_phase <= r_phase + bus.Incr;
            end
            r_wave <= w_next_wave;
        end
    end

    assign bus.Waveform = r_wave;
endmodule

// File: tb/tb_wave_gen.sv
// Directed self-checking bench for wave_gen at WAVE_DEPTH=8.
module tb_wave_gen;
    logic Clock;
    logic Reset;
    int   n_checks;
    int   n_err;

    wave_gen_if #(.WAVE_DEPTH(8)) bus ();

    wave_gen #(.WAVE_DEPTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic open_gate();
        bus.GateOpen = 1'b1;
        tick();
        bus.GateOpen = 1'b0;
    endtask

    initial begin
        logic [7:0] tri_exp [4];
        n_checks       = 0;
        n_err          = 0;
        Reset          = 1'b1;
        bus.GateOpen   = 1'b0;
        bus.GateClose  = 1'b0;
        bus.Incr       = 8'h00;
        bus.WaveType   = 2'b00;
        bus.PulseWidth = 8'h00;
        #1;
        check("reset_async", bus.Waveform, 8'h00);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        tick();
        check("idle_after_reset", bus.Waveform, 8'h00);

`ifndef WAVE_GEN_ENVELOPE_EN
        // Sawtooth from reset
        bus.Incr     = 8'h0F;
        bus.WaveType = 2'b00;
        bus.GateOpen = 1'b1;
        tick();
        check("saw_open_edge", bus.Waveform, 8'h00);
        bus.GateOpen = 1'b0;
        tick(); check("saw_s0", bus.Waveform, 8'h00);
        tick(); check("saw_s1", bus.Waveform, 8'h0F);
        tick(); check("saw_s2", bus.Waveform, 8'h1E);
        tick(); check("saw_s3", bus.Waveform, 8'h2D);

        // Silent phase wrap
        bus.Incr = 8'hFF;
        open_gate();
        tick(); check("wrap_s0", bus.Waveform, 8'h00);
        tick(); check("wrap_s1", bus.Waveform, 8'hFF);
        tick(); check("wrap_s2", bus.Waveform, 8'hFE);

        // Pulse, 50% duty
        bus.WaveType   = 2'b01;
        bus.PulseWidth = 8'h80;
        bus.Incr       = 8'h10;
        open_gate();
        for (int i = 0; i < 32; i++) begin
            tick();
            check($sformatf("pulse_s%0d", i), bus.Waveform, ((i % 16) < 8) ? 8'hFF : 8'h00);
        end

        // Triangle
        tri_exp[0] = 8'h00; tri_exp[1] = 8'h80; tri_exp[2] = 8'hFF; tri_exp[3] = 8'h7F;
        bus.WaveType = 2'b10;
        bus.Incr     = 8'h40;
        open_gate();
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("tri_s%0d", i), bus.Waveform, tri_exp[i % 4]);
        end

        // Reverse sawtooth
        bus.WaveType = 2'b11;
        bus.Incr     = 8'h20;
        open_gate();
        tick(); check("rsaw_s0", bus.Waveform, 8'hFF);
        tick(); check("rsaw_s1", bus.Waveform, 8'hDF);
        tick(); check("rsaw_s2", bus.Waveform, 8'hBF);

        // PulseWidth zero is constant low
        bus.WaveType   = 2'b01;
        bus.PulseWidth = 8'h00;
        bus.Incr       = 8'h10;
        open_gate();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("pw0_s%0d", i), bus.Waveform, 8'h00);
        end

        // Live control changes keep phase
        bus.WaveType = 2'b00;
        bus.Incr     = 8'h10;
        open_gate();
        tick(); check("live_s0", bus.Waveform, 8'h00);
        tick(); check("live_s1", bus.Waveform, 8'h10);
        tick(); check("live_s2", bus.Waveform, 8'h20);
        bus.WaveType = 2'b11;
        tick(); check("live_type", bus.Waveform, 8'hCF);
        bus.Incr = 8'h01;
        tick(); check("live_incr0", bus.Waveform, 8'hBF);
        tick(); check("live_incr1", bus.Waveform, 8'hBE);

        // Gate close, reopen, simultaneous requests
        bus.WaveType = 2'b00;
        bus.Incr     = 8'h10;
        tick(); check("close_pre", bus.Waveform, 8'h42);
        bus.GateClose = 1'b1;
        tick(); check("close_edge", bus.Waveform, 8'h52);
        bus.GateClose = 1'b0;
        tick(); check("closed_0", bus.Waveform, 8'h00);
        tick(); check("closed_1", bus.Waveform, 8'h00);
        bus.GateOpen = 1'b1;
        tick(); check("reopen_edge", bus.Waveform, 8'h00);
        bus.GateOpen = 1'b0;
        tick(); check("reopen_s0", bus.Waveform, 8'h00);
        tick(); check("reopen_s1", bus.Waveform, 8'h10);
        bus.GateOpen  = 1'b1;
        bus.GateClose = 1'b1;
        tick(); check("both_edge", bus.Waveform, 8'h20);
        bus.GateOpen  = 1'b0;
        bus.GateClose = 1'b0;
        tick(); check("both_s0", bus.Waveform, 8'h00);
        tick(); check("both_s1", bus.Waveform, 8'h10);

        // Asynchronous reset between edges
        #2;
        Reset = 1'b1;
        #1;
        check("reset_mid", bus.Waveform, 8'h00);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_%0d", i), bus.Waveform, 8'h00);
        end
        bus.GateOpen = 1'b1;
        tick(); check("post_reset_open", bus.Waveform, 8'h00);
        bus.GateOpen = 1'b0;
        tick(); check("post_reset_s0", bus.Waveform, 8'h00);
        tick(); check("post_reset_s1", bus.Waveform, 8'h10);
`else
        begin
            int env_m;
            int exp_w;
            bus.WaveType = 2'b00;
            bus.Incr     = 8'h40;
            open_gate();
            tick();
            check("env_first", bus.Waveform, 8'h00);
            bus.Incr = 8'h00;
            env_m = 1;
            for (int i = 0; i < 300; i++) begin
                tick();
                exp_w = (env_m == 255) ? 32'h40 : ((32'h40 * env_m) >> 8);
                check($sformatf("env_attack_%0d", i), bus.Waveform, exp_w[7:0]);
                if (env_m < 255) env_m++;
            end
            bus.GateClose = 1'b1;
            tick(); check("env_close_edge", bus.Waveform, 8'h40);
            bus.GateClose = 1'b0;
            for (int i = 0; i < 260; i++) begin
                tick();
                exp_w = (env_m == 255) ? 32'h40 : ((32'h40 * env_m) >> 8);
                check($sformatf("env_decay_%0d", i), bus.Waveform, exp_w[7:0]);
                if (env_m > 0) env_m--;
            end
            check("env_final", bus.Waveform, 8'h00);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
